// File: rtl/udcnt_mod_if.sv
// Control and status bundle for udcnt_mod. The master drives the controls and the
// slave (the counter) drives the count and flags.
interface udcnt_mod_if #(
    parameter int unsigned WIDTH = 4
);
    logic             Load;
    logic             EN;
    logic             Up_Dn;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Limit;
    logic             Sat;
    logic [WIDTH-1:0] Q;
    logic             CO;
    logic             TC;
    logic             Ovf;

    modport master (
        output Load, EN, Up_Dn, D, Limit, Sat,
        input  Q, CO, TC, Ovf
    );

    modport slave (
        input  Load, EN, Up_Dn, D, Limit, Sat,
        output Q, CO, TC, Ovf
    );
endinterface

// File: rtl/udcnt_mod.sv
// Up/down counter with parallel load, programmable modulus, carry/borrow pulse and cascade TC.
// Define UDCNT_SAT_EN to build the saturating mode (Sat input, sticky Ovf flag).
module udcnt_mod #(
    parameter int unsigned      WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic        CLK,
    input logic        MR,
    udcnt_mod_if.slave bus
);
    logic [WIDTH-1:0] q_q, q_d;
    logic             co_q, co_d;
    logic             boundary;
    logic             sat_mode;
    logic             ovf_set;

`ifdef UDCNT_SAT_EN
    logic ovf_q, ovf_d;
    assign sat_mode = bus.Sat;
`else
    logic unused_sat;
    assign unused_sat = bus.Sat;
    assign sat_mode   = 1'b0;
`endif

    // The boundary compare precedes the step, so the step never overflows WIDTH.
    always_comb begin
        boundary = bus.Up_Dn ? (q_q >= bus.Limit) : (q_q == '0);
    end

    always_comb begin
        q_d     = q_q;
        co_d    = 1'b0;
        ovf_set = 1'b0;
        if (bus.Load) begin
            q_d = bus.D;
        end else if (bus.EN) begin
            if (boundary) begin
                if (sat_mode) begin
                    ovf_set = 1'b1;
                end else begin
                    q_d  = bus.Up_Dn ? '0 : bus.Limit;
                    co_d = 1'b1;
                end
            end else begin
                q_d = bus.Up_Dn ? q_q + WIDTH'(1) : q_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge MR) begin
        if (!MR) begin
            q_q  <= RESET_VAL;
            co_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            co_q <= co_d;
        end
    end

`ifdef UDCNT_SAT_EN
    always_comb begin
        ovf_d = ovf_q;
        if (bus.Load) begin
            ovf_d = 1'b0;
        end else if (ovf_set) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge MR) begin
        if (!MR) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.Ovf = ovf_q;
`else
    logic unused_ovf_set;
    assign unused_ovf_set = ovf_set;
    assign bus.Ovf        = 1'b0;
`endif

    assign bus.Q  = q_q;
    assign bus.CO = co_q;
    assign bus.TC = bus.EN & boundary;
endmodule
